// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: FSM state encodings, frame length, command bytes
// and the frame builder used when a transfer is accepted.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    XMIT      = 3'd2,
    ACK       = 3'd3,
    WAIT_IDLE = 3'd4
  } ps2_state_e;

  localparam int FRAME_LEN = 11;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  // Bit 0 goes on the wire first: start(0), data LSB first, odd parity, stop(1).
  function automatic logic [FRAME_LEN-1:0] build_frame(input logic [7:0] b);
    return {1'b1, ~^b, b, 1'b0};
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command-side interface of the PS/2 host transmitter.
// Handshake: a byte is taken in the cycle where tx_valid && tx_ready; tx_data
// must be stable in that cycle; tx_valid while tx_ready is low is ignored.
interface ps2_host_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       ack_err;
  logic       timeout;

  modport master (output tx_valid, tx_data,
                  input  tx_ready, busy, done, ack_err, timeout);
  modport slave  (input  tx_valid, tx_data,
                  output tx_ready, busy, done, ack_err, timeout);
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus glitch filter for one PS/2 line; the filtered
// value follows only after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic line_in,
  output logic filt,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q, sync_d;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync_d = {sync_q[0], line_in};
    filt_d = filt_q;
    fall_d = 1'b0;
    cnt_d  = '0;
    if (sync_q[1] != filt_q) begin
      if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_d = sync_q[1];
        fall_d = filt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      filt_q <= filt_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign filt = filt_q;
  assign fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, then shifts one command
// frame out on device-generated clock falls and checks the device ACK.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 2800,
  parameter int TIMEOUT_CYCLES = 420000,
  parameter int FILTER_LEN     = 8
) (
  input  logic                clk,
  input  logic                reset,
  ps2_host_tx_if.slave        tx_if,
  input  logic                ps2_clk_in,
  input  logic                ps2_data_in,
  output logic                ps2_clk_oe,
  output logic                ps2_data_oe,
  output ps2_state_e          dbg_state
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  ps2_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [FRAME_LEN-1:0] frame_q, frame_d;

  logic clk_filt, clk_fall, data_filt, data_fall_unused;
  logic tmo_hit;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2_clk_in),
    .filt    (clk_filt),
    .fall    (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk     (clk),
    .reset   (reset),
    .line_in (ps2_data_in),
    .filt    (data_filt),
    .fall    (data_fall_unused)
  );

  // The same counter times the inhibit period and, from XMIT onward, the timeout.
  assign tmo_hit = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    bit_cnt_d        = bit_cnt_q;
    frame_d          = frame_q;
    ps2_clk_oe       = 1'b0;
    ps2_data_oe      = 1'b0;
    tx_if.tx_ready   = 1'b0;
    tx_if.done       = 1'b0;
    tx_if.ack_err    = 1'b0;
    tx_if.timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        tx_if.tx_ready = 1'b1;
        cnt_d          = '0;
        bit_cnt_d      = '0;
        if (tx_if.tx_valid) begin
          frame_d = build_frame(tx_if.tx_data);
          state_d = INHIBIT;
        end
      end
      INHIBIT: begin
        ps2_clk_oe = 1'b1;
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          ps2_data_oe = 1'b1;
          cnt_d       = '0;
          state_d     = XMIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      XMIT: begin
        if (tmo_hit) begin
          tx_if.timeout = 1'b1;
          state_d       = IDLE;
        end else begin
          ps2_data_oe = ~frame_q[0];
          cnt_d       = cnt_q + 1'b1;
          if (clk_fall) begin
            frame_d   = {1'b1, frame_q[FRAME_LEN-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            // The tenth fall puts the stop bit (a released line) on the wire.
            if (bit_cnt_q == 4'(FRAME_LEN - 2)) state_d = ACK;
          end
        end
      end
      ACK: begin
        if (tmo_hit) begin
          tx_if.timeout = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (clk_fall) begin
            tx_if.done    = ~data_filt;
            tx_if.ack_err = data_filt;
            state_d       = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (tmo_hit) begin
          tx_if.timeout = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (clk_filt && data_filt) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line enables decode straight from state_q, so reset releases them at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      frame_q   <= '1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      frame_q   <= frame_d;
    end
  end

  assign tx_if.busy = (state_q != IDLE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host and every observation is compared against hand-computed frame values.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int INH = 20;
  localparam int TMO = 5000;

  // Wire images {stop, parity, data[7:0], start}, parity worked out by hand.
  localparam logic [10:0] FR_ED = 11'h7DA;
  localparam logic [10:0] FR_07 = 11'h40E;
  localparam logic [10:0] FR_FF = 11'h7FE;
  localparam logic [10:0] FR_EE = 11'h7DC;
  localparam logic [10:0] FR_5A = 11'h6B4;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic dev_clk, dev_data;
  ps2_state_e dbg_state;

  ps2_host_tx_if tx_if ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_if       (tx_if.slave),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .dbg_state   (dbg_state)
  );

  // Open-drain bus: either side can pull a line low.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0, ack_err_cnt = 0, tmo_cnt = 0;

  always @(negedge clk) begin
    if (tx_if.done)    done_cnt++;
    if (tx_if.ack_err) ack_err_cnt++;
    if (tx_if.timeout) tmo_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_tx(input logic [7:0] b);
    check("ready_before_send", 32'(tx_if.tx_ready), 1);
    tx_if.tx_data  = b;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
    check("busy_after_accept", 32'(tx_if.busy), 1);
  endtask

  // Device model: measures the inhibit, then gives n_falls clock pulses with a
  // 40-cycle half period, sampling the data line late in each high phase.
  task automatic dev_xfer(input int n_falls, input bit do_ack, input int glitch_k,
                          output logic [10:0] bits, output int inh_n, output int inh_d);
    int guard;
    bits  = '1;
    inh_n = 0;
    inh_d = 0;
    guard = 0;
    while (!ps2_clk_oe && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check("inhibit_seen", 32'(ps2_clk_oe), 1);
    while (ps2_clk_oe && inh_n < 1000) begin
      inh_n++;
      if (ps2_data_oe) inh_d++;
      @(negedge clk);
    end
    for (int k = 0; k < n_falls; k++) begin
      if (k == glitch_k) begin
        repeat (5) @(negedge clk);
        dev_clk = 1'b0;
        @(negedge clk);
        dev_clk = 1'b1;
        repeat (14) @(negedge clk);
      end else begin
        repeat (20) @(negedge clk);
      end
      bits[k] = ps2_data_in;
      if (k == 10 && do_ack) dev_data = 1'b0;
      repeat (20) @(negedge clk);
      dev_clk = 1'b0;
      repeat (40) @(negedge clk);
      dev_clk = 1'b1;
    end
    if (n_falls > 0) begin
      repeat (10) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int guard;
    guard = 0;
    while (dbg_state != IDLE && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check(tag, 32'(dbg_state), 32'(IDLE));
  endtask

  // ---------------- stimulus ----------------
  logic [10:0] bits;
  int inh_n, inh_d;
  int d0, a0, t0;
  int rdy_n, xmit_n, oe_n;
  bit seen_done, got_tmo;

  initial begin
    reset          = 1'b1;
    dev_clk        = 1'b1;
    dev_data       = 1'b1;
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(tx_if.tx_ready), 1);
    check("rst_busy", 32'(tx_if.busy), 0);
    check("rst_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_pulses", {29'd0, tx_if.done, tx_if.ack_err, tx_if.timeout}, 0);

    // 0xED with ACK
    d0 = done_cnt; a0 = ack_err_cnt;
    start_tx(CMD_SET_LEDS);
    dev_xfer(11, 1'b1, -1, bits, inh_n, inh_d);
    check("ed_inhibit_len", 32'(inh_n), INH);
    check("ed_start_in_inhibit", 32'(inh_d), 1);
    check("ed_bits", 32'(bits), 32'(FR_ED));
    check("ed_done", 32'(done_cnt - d0), 1);
    check("ed_no_ack_err", 32'(ack_err_cnt - a0), 0);
    wait_idle("ed_idle");
    check("ed_busy_low", 32'(tx_if.busy), 0);
    check("ed_ready", 32'(tx_if.tx_ready), 1);

    // 0x07, device leaves data high at ACK
    d0 = done_cnt; a0 = ack_err_cnt;
    start_tx(8'h07);
    dev_xfer(11, 1'b0, -1, bits, inh_n, inh_d);
    check("x07_bits", 32'(bits), 32'(FR_07));
    check("x07_parity", 32'(bits[9]), 0);
    check("x07_ack_err", 32'(ack_err_cnt - a0), 1);
    check("x07_no_done", 32'(done_cnt - d0), 0);
    wait_idle("x07_idle");

    // 0x00, device never clocks: timeout
    d0 = done_cnt; t0 = tmo_cnt;
    start_tx(8'h00);
    dev_xfer(0, 1'b0, -1, bits, inh_n, inh_d);
    xmit_n = 0; got_tmo = 1'b0;
    for (int i = 0; i < 6000 && !got_tmo; i++) begin
      if (dbg_state == XMIT) xmit_n++;
      if (tx_if.timeout) got_tmo = 1'b1;
      else @(negedge clk);
    end
    check("tmo_seen", 32'(got_tmo), 1);
    check("tmo_xmit_cycles", 32'(xmit_n), TMO);
    check("tmo_lines_released", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    @(negedge clk);
    check("tmo_state_idle", 32'(dbg_state), 32'(IDLE));
    check("tmo_ready", 32'(tx_if.tx_ready), 1);
    check("tmo_pulse_count", 32'(tmo_cnt - t0), 1);
    check("tmo_no_done", 32'(done_cnt - d0), 0);

    // 0xFF with tx_valid held and 0x12 presented mid-frame
    d0 = done_cnt;
    tx_if.tx_data  = CMD_RESET;
    tx_if.tx_valid = 1'b1;
    @(negedge clk);
    rdy_n = 0; seen_done = 1'b0;
    fork
      dev_xfer(11, 1'b1, -1, bits, inh_n, inh_d);
      begin
        for (int i = 0; i < 3000 && !seen_done; i++) begin
          if (i == 300) tx_if.tx_data = 8'h12;
          if (tx_if.done) seen_done = 1'b1;
          else begin
            if (tx_if.tx_ready) rdy_n++;
            @(negedge clk);
          end
        end
        tx_if.tx_valid = 1'b0;
      end
    join
    check("ff_done_seen", 32'(seen_done), 1);
    check("ff_ready_low_while_busy", 32'(rdy_n), 0);
    check("ff_bits", 32'(bits), 32'(FR_FF));
    check("ff_done_count", 32'(done_cnt - d0), 1);
    wait_idle("ff_idle");
    oe_n = 0;
    for (int i = 0; i < 50; i++) begin
      if (ps2_clk_oe || dbg_state != IDLE) oe_n++;
      @(negedge clk);
    end
    check("ff_no_second_frame", 32'(oe_n), 0);

    // reset during data bit 4 of 0xED (bit 4 is 0, so data is pulled low)
    start_tx(CMD_SET_LEDS);
    dev_xfer(5, 1'b0, -1, bits, inh_n, inh_d);
    repeat (20) @(negedge clk);
    check("bit4_data_oe", 32'(ps2_data_oe), 1);
    #2 reset = 1'b1;
    #1 check("rst_mid_oe", {30'd0, ps2_clk_oe, ps2_data_oe}, 0);
    check("rst_mid_state", 32'(dbg_state), 32'(IDLE));
    @(negedge clk);
    reset    = 1'b0;
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 32'(tx_if.tx_ready), 1);
    d0 = done_cnt;
    start_tx(CMD_ECHO);
    dev_xfer(11, 1'b1, -1, bits, inh_n, inh_d);
    check("ee_bits", 32'(bits), 32'(FR_EE));
    check("ee_done", 32'(done_cnt - d0), 1);
    wait_idle("ee_idle");

    // one-cycle glitch on ps2_clk_in during XMIT
    d0 = done_cnt; a0 = ack_err_cnt;
    start_tx(8'h5A);
    dev_xfer(11, 1'b1, 3, bits, inh_n, inh_d);
    check("glitch_bits", 32'(bits), 32'(FR_5A));
    check("glitch_done", 32'(done_cnt - d0), 1);
    check("glitch_no_ack_err", 32'(ack_err_cnt - a0), 0);
    wait_idle("glitch_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: the sending counterpart to the existing PS/2 keyboard receiver.
- Sends command bytes to the keyboard, e.g. 0xED LED-set for Caps/Scroll lock, or 0xFF reset.
- Runs on cpuClock (28 MHz) alongside the receiver. Drives the shared ps2Clk/ps2Data open-drain lines through output-enable signals.
- The top level gates the receiver with busy so it ignores host-generated frames.

Parameters:
- INHIBIT_CYCLES, 2800: clock-low inhibit time in clk cycles (100 us at 28 MHz).
- TIMEOUT_CYCLES, 420000: maximum time from clock release to ACK sample (15 ms).
- FILTER_LEN, 8: consecutive equal samples needed before a synchronized PS/2 line changes its filtered value.

Ports:
- clk  in  1  system clock (cpuClock).
- reset  in  1  asynchronous, active-high reset.
- tx_valid  in  1  request to send tx_data.
- tx_data  in  8  byte to send.
- tx_ready  out  1  high in IDLE only; a transfer is accepted when tx_valid && tx_ready.
- ps2_clk_in  in  1  raw ps2Clk pad input.
- ps2_data_in  in  1  raw ps2Data pad input.
- ps2_clk_oe  out  1  1 = pull ps2Clk low; 0 = release.
- ps2_data_oe  out  1  1 = pull ps2Data low; 0 = release.
- busy  out  1  high from accept until return to IDLE.
- done  out  1  one-cycle pulse: frame completed and device ACK seen.
- ack_err  out  1  one-cycle pulse: frame completed without ACK (data high at ACK sample).
- timeout  out  1  one-cycle pulse: frame aborted by timeout.

Behaviour:
- Reset:
  - All outputs 0 except tx_ready = 1. State is IDLE, counters 0.
  - Reset asserted mid-frame releases both lines immediately, asynchronously.
- Line conditioning:
  - Each input passes through a 2-FF synchronizer, then a filter.
  - The filtered value updates only after FILTER_LEN consecutive identical synchronized samples.
  - clk_fall is a one-cycle pulse when the filtered clock goes 1->0.
  - Filtered lines reset to 1.
- Accept: latch tx_data into an 11-bit sequence. Parity = ~^tx_data (odd parity).
- States:
  - IDLE: tx_ready = 1, both oe = 0. On accept, go to INHIBIT the next cycle and assert busy.
  - INHIBIT:
    - clk_oe = 1 for exactly INHIBIT_CYCLES cycles.
    - data_oe = 1 during the final cycle of the inhibit period (start bit).
    - Then go to XMIT with clk_oe = 0, data_oe = 1, bit index 0, timeout counter cleared.
  - XMIT: on each clk_fall, drive the next bit with data_oe = ~bit.
    - Falls 1-8 drive data bits 0-7, LSB first.
    - Fall 9 drives parity.
    - Fall 10 drives stop: data_oe = 0.
    - Then go to ACK.
  - ACK: on the next clk_fall, sample filtered data.
    - 0: pulse done.
    - 1: pulse ack_err.
    - Either way, go to WAIT_IDLE.
  - WAIT_IDLE: both oe = 0. When filtered clock and data are both 1, go to IDLE (busy = 0, tx_ready = 1).
- Timeout:
  - The counter runs in XMIT, ACK and WAIT_IDLE.
  - On reaching TIMEOUT_CYCLES-1: release both lines, pulse timeout, go to IDLE.
  - Timeout has priority over a simultaneous clk_fall.
- tx_valid outside IDLE is ignored; no queuing.
- The module never drives clk_oe after INHIBIT ends. The device generates all clocks.
- Pulses done, ack_err and timeout are mutually exclusive and asserted in the cycle of the deciding event.
- Spurious clk_fall in IDLE or INHIBIT is ignored.

Decomposition:
- Shared PS/2 definitions include file (used with the receiver):
  - state encodings IDLE/INHIBIT/XMIT/ACK/WAIT_IDLE;
  - frame length constant 11;
  - command constants CMD_SET_LEDS = 8'hED, CMD_RESET = 8'hFF, CMD_ECHO = 8'hEE.
- One sub-module, ps2_line_filter (synchronizer plus FILTER_LEN glitch filter, filtered output and fall pulse). Instantiated twice, for clock and data.

Test Plan:
- Bench parameters: INHIBIT_CYCLES = 20, TIMEOUT_CYCLES = 5000, FILTER_LEN = 2. The device model clocks at a 40-cycle half-period.
- Send 0xED with device ACK:
  - clk_oe is high for exactly 20 cycles;
  - sampled bits are 0 (start), then 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - done pulses once; busy then falls; tx_ready = 1.
- Send 0x07 with the device leaving data high at ACK:
  - parity bit observed 0;
  - ack_err pulses once, done stays 0.
- Send 0x00 with a device that never clocks:
  - after 5000 cycles in XMIT, timeout pulses;
  - ps2_data_oe = 0, state returns to IDLE.
- tx_valid held high during a 0xFF transfer, with 0x12 presented mid-frame: only 0xFF is transmitted, and tx_ready stays 0 until done.
- Reset asserted during data bit 4:
  - both oe drop to 0 in the same cycle, without waiting for a clock edge;
  - after release, tx_ready = 1 and a new 0xEE send completes normally.
- 1-cycle glitch on ps2_clk_in during XMIT: no bit advance; the frame still completes with correct bits.
